memory_access_controller: RTL and testbench

//   MEM-stage sequencer between the EX/MEM pipeline register and memory_data_memory.
//   - Turns load/store requests of byte, half or word size into word-aligned data-memory accesses.
//   - Implements sub-word stores as read-modify-write (RMW) sequences.
//   - Models memory latency with a programmable wait count.
//   - Holds the pipeline with stall until each access completes.

---
 rtl/memory_access_controller_if.sv | 32 +++
 rtl/memory_access_controller.sv | 181 ++++++++++++++++++
 tb/tb_memory_access_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_controller_if.sv
// memory_access_controller_if
//   Bundles the MEM-stage request/response signals and the data-memory
//   side signals of memory_access_controller.
//   master : pipeline / environment side (drives requests and dm_readdata)
//   slave  : the controller (drives response and data-memory control)
interface memory_access_controller_if;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        loadUnsigned;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        done;
    logic        addrError;
    logic        dm_memRead;
    logic        dm_memWrite;
    logic [31:0] dm_address;
    logic [31:0] dm_writedata;
    logic [31:0] dm_readdata;

    modport master (
        output memRead, memWrite, memSize, loadUnsigned, address, writedata, dm_readdata,
        input  readdata, stall, done, addrError, dm_memRead, dm_memWrite, dm_address, dm_writedata
    );

    modport slave (
        input  memRead, memWrite, memSize, loadUnsigned, address, writedata, dm_readdata,
        output readdata, stall, done, addrError, dm_memRead, dm_memWrite, dm_address, dm_writedata
    );
endinterface

// File: rtl/memory_access_controller.sv
// memory_access_controller
//   MEM-stage sequencer: turns byte/half/word loads and stores into
//   word-aligned data-memory accesses. Sub-word stores are done as
//   read-modify-write. Each data-memory phase is held WAIT_CYCLES extra
//   cycles; the pipeline is stalled until done pulses.
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; abandons any access in flight
//   bus    : slave modport of memory_access_controller_if (request,
//            response and data-memory signals)
module memory_access_controller #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic                          clk,
    input logic                          reset,
    memory_access_controller_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    // Big-endian lane extraction with sign/zero extension; word passes through.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed big-endian lane of word with the right-justified store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[31:24] = data[7:0];
                    2'd1:    r[23:16] = data[7:0];
                    2'd2:    r[15:8]  = data[7:0];
                    default: r[7:0]   = data[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[15:0]  = data[15:0];
                else        r[31:16] = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [3:0]  cnt_r;
    logic [31:0] readdata_r;
    logic [31:0] wdata_r;
    logic        last_s;
    logic        req_s;
    logic        err_s;
    logic [31:0] word_addr_s;

    assign last_s      = (cnt_r == WAIT_C);
    assign req_s       = bus.memRead | bus.memWrite;
    assign word_addr_s = {bus.address[31:2], 2'b00};
    assign err_s       = req_s & ((bus.memRead & bus.memWrite) |
                                  (bus.memSize == 2'b11) |
                                  ((bus.memSize == 2'b01) & bus.address[0]) |
                                  ((bus.memSize == 2'b10) & (bus.address[1:0] != 2'b00)));

    // State register and phase counter; counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            if (state_next_s != state_r)
                cnt_r <= 4'd0;
            else if (((state_r == READ) || (state_r == WRITE)) && !last_s)
                cnt_r <= cnt_r + 4'd1;
            else
                cnt_r <= cnt_r;
        end
    end

    // Next-state logic. In READ, memWrite still high means this is an RMW read.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (err_s)                     state_next_s = ERR;
                else if (bus.memRead)          state_next_s = READ;
                else if (bus.memWrite)         state_next_s = (bus.memSize == 2'b10) ? WRITE : READ;
                else                           state_next_s = IDLE;
            end
            READ: begin
                if (last_s) state_next_s = bus.memWrite ? WRITE : DONE;
                else        state_next_s = READ;
            end
            WRITE: begin
                if (last_s) state_next_s = DONE;
                else        state_next_s = WRITE;
            end
            DONE:    state_next_s = IDLE;
            ERR:     state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Data registers: load result, and the word to write (store data or merged RMW word).
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_r <= 32'd0;
            wdata_r    <= 32'd0;
        end else begin
            if ((state_r == IDLE) && (state_next_s == WRITE))
                wdata_r <= bus.writedata;
            else if ((state_r == READ) && last_s && bus.memWrite)
                wdata_r <= store_merge(bus.dm_readdata, bus.writedata, bus.memSize, bus.address[1:0]);
            else
                wdata_r <= wdata_r;
            if ((state_r == READ) && last_s && !bus.memWrite)
                readdata_r <= load_extract(bus.dm_readdata, bus.memSize, bus.address[1:0], bus.loadUnsigned);
            else
                readdata_r <= readdata_r;
        end
    end

    // Output decode from the registered state; stall also covers the request cycle.
    always_comb begin
        bus.stall        = 1'b0;
        bus.done         = 1'b0;
        bus.addrError    = 1'b0;
        bus.dm_memRead   = 1'b0;
        bus.dm_memWrite  = 1'b0;
        bus.dm_address   = 32'd0;
        bus.dm_writedata = 32'd0;
        case (state_r)
            IDLE: bus.stall = req_s;
            READ: begin
                bus.stall      = 1'b1;
                bus.dm_memRead = 1'b1;
                bus.dm_address = word_addr_s;
            end
            WRITE: begin
                bus.stall        = 1'b1;
                bus.dm_address   = word_addr_s;
                bus.dm_writedata = wdata_r;
                bus.dm_memWrite  = last_s;
            end
            DONE: bus.done = 1'b1;
            ERR: begin
                bus.done      = 1'b1;
                bus.addrError = 1'b1;
            end
            default: bus.stall = 1'b0;
        endcase
    end

    assign bus.readdata = readdata_r;
endmodule

// File: tb/tb_memory_access_controller.sv
// tb_memory_access_controller
//   Directed bench: dut_a runs with WAIT_CYCLES=1, dut_b with WAIT_CYCLES=0.
//   Each has its own word-array data memory. sel picks which instance the
//   shared request variables reach and whose outputs are observed.
module tb_memory_access_controller;
    logic clk = 1'b0;
    logic reset;
    logic mem_clr;
    logic sel;
    logic rd, wr, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wd;
    int nchecks = 0;
    int nerrors = 0;

    memory_access_controller_if ifa ();
    memory_access_controller_if ifb ();

    memory_access_controller #(.WAIT_CYCLES(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    memory_access_controller #(.WAIT_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    assign ifa.memRead = rd & ~sel;   assign ifb.memRead = rd & sel;
    assign ifa.memWrite = wr & ~sel;  assign ifb.memWrite = wr & sel;
    assign ifa.memSize = sz;          assign ifb.memSize = sz;
    assign ifa.loadUnsigned = uns;    assign ifb.loadUnsigned = uns;
    assign ifa.address = addr;        assign ifb.address = addr;
    assign ifa.writedata = wd;        assign ifb.writedata = wd;

    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    assign ifa.dm_readdata = mem_a[ifa.dm_address[5:2]];
    assign ifb.dm_readdata = mem_b[ifb.dm_address[5:2]];

    // Data memories: cleared once at start, written on dm_memWrite.
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 32'd0;
                mem_b[i] <= 32'd0;
            end
        end else begin
            if (ifa.dm_memWrite) mem_a[ifa.dm_address[5:2]] <= ifa.dm_writedata;
            if (ifb.dm_memWrite) mem_b[ifb.dm_address[5:2]] <= ifb.dm_writedata;
        end
    end

    logic [31:0] o_rd, o_dmad, o_dmwd;
    logic o_stall, o_done, o_aerr, o_dmrd, o_dmwr;
    assign o_rd    = sel ? ifb.readdata     : ifa.readdata;
    assign o_dmad  = sel ? ifb.dm_address   : ifa.dm_address;
    assign o_dmwd  = sel ? ifb.dm_writedata : ifa.dm_writedata;
    assign o_stall = sel ? ifb.stall        : ifa.stall;
    assign o_done  = sel ? ifb.done         : ifa.done;
    assign o_aerr  = sel ? ifb.addrError    : ifa.addrError;
    assign o_dmrd  = sel ? ifb.dm_memRead   : ifa.dm_memRead;
    assign o_dmwr  = sel ? ifb.dm_memWrite  : ifa.dm_memWrite;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request starting in the current cycle (called #1 after a posedge)
    // and observe it until done; returns #1 after the posedge following done with
    // the request removed. lat = cycles from request cycle to done cycle.
    task automatic req(input logic r, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int nrd, output int nwr, output int nst,
                       output logic [31:0] rdat, output logic aerr,
                       output logic [31:0] wrdat, output logic [31:0] dmaddr);
        rd = r; wr = w; sz = s; uns = u; addr = a; wd = d;
        lat = -1; nrd = 0; nwr = 0; nst = 0;
        rdat = 32'hx; aerr = 1'bx; wrdat = 32'd0; dmaddr = 32'd0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (o_dmrd) begin nrd++; dmaddr = o_dmad; end
            if (o_dmwr) begin nwr++; wrdat = o_dmwd; dmaddr = o_dmad; end
            if (o_stall) nst++;
            if (o_done) begin
                lat = k; rdat = o_rd; aerr = o_aerr;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wd = 32'd0;
    endtask

    int lat, nrd, nwr, nst;
    logic [31:0] rdat, wrdat, dmaddr;
    logic aerr;

    initial begin
        reset = 1'b1; mem_clr = 1'b1; sel = 1'b0;
        rd = 1'b0; wr = 1'b0; sz = 2'b00; uns = 1'b0; addr = 32'd0; wd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readdata", o_rd, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_aerr", {31'd0, o_aerr}, 32'd0);
        check("rst_dm_ctl", {30'd0, o_dmrd, o_dmwr}, 32'd0);
        check("rst_dm_addr", o_dmad, 32'd0);
        check("rst_dm_wdata", o_dmwd, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; mem_clr = 1'b0;

        // 1: word store then word load, WAIT=1
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'd0, 32'd100, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("sw_lat", lat, 32'd3);
        check("sw_nwr", nwr, 32'd1);
        check("sw_nrd", nrd, 32'd0);
        check("sw_wdata", wrdat, 32'd100);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lw_lat", lat, 32'd3);
        check("lw_data", rdat, 32'd100);
        check("lw_nrd", nrd, 32'd2);
        check("lw_nst", nst, 32'd3);
        check("lw_aerr", {31'd0, aerr}, 32'd0);

        // 2: sub-word loads from 0x80817F01 at addr 8
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'd8, 32'h8081_7F01, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("sw8_lat", lat, 32'd3);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'd9, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lb_data", rdat, 32'hFFFF_FF81);
        check("lb_dmaddr", dmaddr, 32'd8);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'd9, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lbu_data", rdat, 32'h0000_0081);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'd8, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lh0_data", rdat, 32'hFFFF_8081);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'd10, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lh2_data", rdat, 32'h0000_7F01);

        // 3: read-modify-write stores on 0x11223344 at addr 12
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'd12, 32'h1122_3344, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'd14, 32'h1234_56AA, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("sb_lat", lat, 32'd5);
        check("sb_nst", nst, 32'd5);
        check("sb_nrd", nrd, 32'd2);
        check("sb_nwr", nwr, 32'd1);
        check("sb_wdata", wrdat, 32'h1122_AA44);
        check("sb_dmaddr", dmaddr, 32'd12);
        check("sb_rdata_keep", rdat, 32'h0000_7F01);
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'd12, 32'hFFFF_BEEF, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("sh_lat", lat, 32'd5);
        check("sh_wdata", wrdat, 32'hBEEF_AA44);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("lw12_data", rdat, 32'hBEEF_AA44);

        // 4: error cases
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd2, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("err_lw_lat", lat, 32'd1);
        check("err_lw_aerr", {31'd0, aerr}, 32'd1);
        check("err_lw_dm", nrd + nwr, 32'd0);
        check("err_rdata_keep", rdat, 32'hBEEF_AA44);
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'd1, 32'd5, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("err_sh_lat", lat, 32'd1);
        check("err_sh_aerr", {31'd0, aerr}, 32'd1);
        check("err_sh_dm", nrd + nwr, 32'd0);
        req(1'b1, 1'b0, 2'b11, 1'b0, 32'd0, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("err_sz_lat", lat, 32'd1);
        check("err_sz_aerr", {31'd0, aerr}, 32'd1);
        check("err_sz_dm", nrd + nwr, 32'd0);
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'd0, 32'd7, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("err_rw_lat", lat, 32'd1);
        check("err_rw_aerr", {31'd0, aerr}, 32'd1);
        check("err_rw_dm", nrd + nwr, 32'd0);
        check("err_mem0_keep", mem_a[0], 32'd100);

        // 5: reset during the WRITE wait of a byte store to addr 12
        rd = 1'b0; wr = 1'b1; sz = 2'b00; addr = 32'd12; wd = 32'h0000_0055;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst5_in_write", {30'd0, o_stall, o_dmwr}, 32'd2);
        reset = 1'b1; wr = 1'b0; addr = 32'd0; wd = 32'd0;
        @(posedge clk);
        @(negedge clk);
        check("rst5_ctl", {27'd0, o_stall, o_done, o_aerr, o_dmrd, o_dmwr}, 32'd0);
        check("rst5_readdata", o_rd, 32'd0);
        check("rst5_dm_addr", o_dmad, 32'd0);
        check("rst5_dm_wdata", o_dmwd, 32'd0);
        check("rst5_mem_keep", mem_a[3], 32'hBEEF_AA44);
        @(posedge clk); #1;
        reset = 1'b0;
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd12, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("rst5_lw_data", rdat, 32'hBEEF_AA44);

        // 6: WAIT=0 instance, back-to-back requests at addr 4
        sel = 1'b1;
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'hCAFE_F00D, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("w0_sw_lat", lat, 32'd2);
        check("w0_sw_nwr", nwr, 32'd1);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("w0_lw_lat", lat, 32'd2);
        check("w0_lw_data", rdat, 32'hCAFE_F00D);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_0077, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("w0_sb_lat", lat, 32'd3);
        check("w0_sb_wdata", wrdat, 32'hCA77_F00D);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, lat, nrd, nwr, nst, rdat, aerr, wrdat, dmaddr);
        check("w0_lw2_data", rdat, 32'hCA77_F00D);
        check("w0_mem_a_keep", mem_a[1], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
